// File: rtl/clock_divider_gen_pkg.sv
// Shared constants and FSM encoding for the clock-enable / divided-clock generator.
package clock_divider_gen_pkg;

    localparam int CDG_DEFAULT_DIV = 10;
    localparam int CDG_MIN_DIV     = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } cdg_state_e;

endpackage

// File: rtl/clock_divider_gen_period_counter.sv
// Loadable modulo-N period counter with a terminal flag; clear dominates run.
module div_period_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             run_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] modulus_i,
    output logic [WIDTH-1:0] count_o,
    output logic             terminal_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // >= rather than == so a count stranded above a shrunken modulus still wraps.
    assign terminal_o = run_i && (count_q >= (modulus_i - WIDTH'(1)));
    assign count_o    = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (run_i) begin
            count_d = terminal_o ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/clock_divider_gen.sv
// Programmable tick / divided-clock generator; divisor changes take effect only at period boundaries.
module clock_divider_gen
    import clock_divider_gen_pkg::*;
#(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = CDG_DEFAULT_DIV
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Enable,
    input  logic [DIV_WIDTH-1:0] i_Div,
    input  logic                 i_Div_Load,
    output logic                 o_Div_Clk,
    output logic                 o_Tick,
    output logic                 o_Locked,
    output logic                 o_Pending
);

    cdg_state_e           state_q, state_d;
    logic [DIV_WIDTH-1:0] active_div_q, active_div_d;
    logic [DIV_WIDTH-1:0] pending_div_q, pending_div_d;
    logic                 pending_vld_q, pending_vld_d;
    logic                 tick_q, tick_d;
    logic                 div_clk_q, div_clk_d;
    logic                 locked_q, locked_d;
    logic                 pend_out_q, pend_out_d;

    logic                 running;
    logic                 terminal;
    logic                 apply;
    logic [DIV_WIDTH-1:0] count;
    logic [DIV_WIDTH-1:0] load_val;
    logic [DIV_WIDTH:0]   high_len;

    assign running  = (state_q != ST_IDLE) && i_Enable;
    assign load_val = (i_Div < DIV_WIDTH'(CDG_MIN_DIV)) ? DIV_WIDTH'(CDG_MIN_DIV) : i_Div;
    // ceil(N/2) computed one bit wider so N = 2^W-1 does not overflow.
    assign high_len = ({1'b0, active_div_q} + (DIV_WIDTH+1)'(1)) >> 1;

    div_period_counter #(
        .WIDTH (DIV_WIDTH)
    ) u_period (
        .clk_i      (i_Clk),
        .srst_i     (i_Rst),
        .run_i      (running),
        .clear_i    (!running),
        .modulus_i  (active_div_q),
        .count_o    (count),
        .terminal_o (terminal)
    );

    always_comb begin
        active_div_d  = active_div_q;
        pending_div_d = pending_div_q;
        pending_vld_d = pending_vld_q;
        apply         = 1'b0;
        if (state_q == ST_IDLE) begin
            if (i_Div_Load) begin
                active_div_d = load_val;
            end
        end else if (terminal) begin
            // A strobe landing on the boundary beats any older pending value.
            if (i_Div_Load) begin
                active_div_d  = load_val;
                pending_vld_d = 1'b0;
                apply         = 1'b1;
            end else if (pending_vld_q) begin
                active_div_d  = pending_div_q;
                pending_vld_d = 1'b0;
                apply         = 1'b1;
            end
        end else if (i_Div_Load) begin
            pending_div_d = load_val;
            pending_vld_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!i_Enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_SYNC;
                ST_SYNC:   if (terminal && !apply) state_d = ST_LOCKED;
                ST_LOCKED: if (terminal && apply)  state_d = ST_SYNC;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        tick_d     = terminal;
        div_clk_d  = running && ({1'b0, count} < high_len);
        locked_d   = running && (state_q == ST_LOCKED);
        pend_out_d = i_Enable && pending_vld_d;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q       <= ST_IDLE;
            active_div_q  <= DIV_WIDTH'(DEFAULT_DIV);
            pending_div_q <= '0;
            pending_vld_q <= 1'b0;
            tick_q        <= 1'b0;
            div_clk_q     <= 1'b0;
            locked_q      <= 1'b0;
            pend_out_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_div_q  <= active_div_d;
            pending_div_q <= pending_div_d;
            pending_vld_q <= pending_vld_d;
            tick_q        <= tick_d;
            div_clk_q     <= div_clk_d;
            locked_q      <= locked_d;
            pend_out_q    <= pend_out_d;
        end
    end

    assign o_Tick    = tick_q;
    assign o_Div_Clk = div_clk_q;
    assign o_Locked  = locked_q;
    assign o_Pending = pend_out_q;

endmodule

// File: tb/tb_clock_divider_gen.sv
// Directed plus random stimulus for clock_divider_gen, checked each cycle against a period-level model.
module tb_clock_divider_gen;

    logic       clk = 1'b0;
    logic       i_Rst;
    logic       i_Enable;
    logic [7:0] i_Div;
    logic       i_Div_Load;
    logic       o_Div_Clk;
    logic       o_Tick;
    logic       o_Locked;
    logic       o_Pending;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;

    // Model: running flag, position inside period, divisor, pending slot, clean periods since (re)sync.
    bit m_run   = 0;
    int m_pos   = 0;
    int m_n     = 10;
    int m_pend  = 0;
    bit m_has   = 0;
    int m_clean = 0;
    bit e_tick, e_clk, e_lock, e_pend;

    always #5 clk = ~clk;

    clock_divider_gen dut (
        .i_Clk      (clk),
        .i_Rst      (i_Rst),
        .i_Enable   (i_Enable),
        .i_Div      (i_Div),
        .i_Div_Load (i_Div_Load),
        .o_Div_Clk  (o_Div_Clk),
        .o_Tick     (o_Tick),
        .o_Locked   (o_Locked),
        .o_Pending  (o_Pending)
    );

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s cycle=%0d got=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    task automatic model(input bit rst, input bit en, input bit ld, input int div);
        int  cdiv;
        bit  chg;
        cdiv = (div < 2) ? 2 : div;
        if (rst) begin
            m_run = 0; m_pos = 0; m_n = 10; m_has = 0; m_clean = 0;
            e_tick = 0; e_clk = 0; e_lock = 0; e_pend = 0;
            return;
        end
        if (!en) begin
            if (ld) begin
                if (!m_run) m_n = cdiv;
                else begin m_pend = cdiv; m_has = 1; end
            end
            m_run = 0; m_pos = 0;
            e_tick = 0; e_clk = 0; e_lock = 0; e_pend = 0;
            return;
        end
        if (!m_run) begin
            if (ld) m_n = cdiv;
            m_run = 1; m_pos = 0; m_clean = 0;
            e_tick = 0; e_clk = 0; e_lock = 0; e_pend = m_has;
            return;
        end
        e_tick = (m_pos == m_n - 1);
        e_clk  = (m_pos < (m_n + 1) / 2);
        e_lock = (m_clean >= 1);
        if (m_pos == m_n - 1) begin
            chg = ld || m_has;
            if (ld) m_n = cdiv;
            else if (m_has) m_n = m_pend;
            m_has   = 0;
            m_clean = chg ? 0 : m_clean + 1;
            m_pos   = 0;
        end else begin
            m_pos++;
            if (ld) begin m_pend = cdiv; m_has = 1; end
        end
        e_pend = m_has;
    endtask

    task automatic step(input bit rst, input bit en, input bit ld, input int div);
        i_Rst = rst; i_Enable = en; i_Div_Load = ld; i_Div = 8'(div);
        if (ld) $display("cycle %0d: load div=%0d enable=%0b", cyc, div, en);
        @(posedge clk);
        model(rst, en, ld, div);
        @(negedge clk);
        cyc++;
        chk("tick",    o_Tick,    e_tick);
        chk("div_clk", o_Div_Clk, e_clk);
        chk("locked",  o_Locked,  e_lock);
        chk("pending", o_Pending, e_pend);
    endtask

    task automatic wait_pos(input int p);
        int k;
        for (k = 0; k < 200 && !(m_run && m_pos == p); k++) step(0, 1, 0, 0);
        chk("wait_pos_bound", (m_run && m_pos == p), 1'b1);
    endtask

    initial begin
        i_Rst = 1; i_Enable = 0; i_Div = 0; i_Div_Load = 0;

        $display("phase: reset then default divisor");
        repeat (3) step(1, 0, 0, 0);
        repeat (35) step(0, 1, 0, 0);

        $display("phase: disable mid-period, odd divisor loaded in idle");
        wait_pos(4);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 7);
        repeat (30) step(0, 1, 0, 0);

        $display("phase: mid-run reload 10 -> 4");
        step(0, 0, 0, 0);
        step(0, 0, 1, 10);
        repeat (25) step(0, 1, 0, 0);
        wait_pos(3);
        step(0, 1, 1, 4);
        repeat (30) step(0, 1, 0, 0);

        $display("phase: coincident strobe and overwrite");
        wait_pos(m_n - 1);
        step(0, 1, 1, 6);
        repeat (20) step(0, 1, 0, 0);
        wait_pos(0);
        step(0, 1, 1, 5);
        step(0, 1, 0, 0);
        step(0, 1, 1, 8);
        repeat (30) step(0, 1, 0, 0);

        $display("phase: clamp of 0 and 1");
        wait_pos(0);
        step(0, 1, 1, 0);
        repeat (12) step(0, 1, 0, 0);
        step(0, 1, 1, 1);
        repeat (12) step(0, 1, 0, 0);

        $display("phase: reset mid-period");
        step(0, 0, 0, 0);
        step(0, 0, 1, 9);
        repeat (3) step(0, 1, 0, 0);
        wait_pos(5);
        step(1, 1, 0, 0);
        repeat (25) step(0, 1, 0, 0);

        $display("phase: random traffic");
        for (int r = 0; r < 400; r++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) != 0),
                 ($urandom_range(0, 9) == 0), int'($urandom_range(0, 12)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

endmodule
